operand_wakeup_station: RTL and testbench
=========================================

Name: operand_wakeup_station

Overview:
- Small age-ordered reservation station that sits directly downstream of the cold register file's read ports.
- Accepts decoded instructions whose operands may be "hot": still in flight, with a writeback tag in place of data.
- Snoops the writeback bus (addr/tag/data) to capture results for hot operands.
- Issues the oldest fully-ready entry to execute over a valid/ready handshake.

Parameters:
- embedded, 1, 1 = 16 architectural regs (4-bit addr); 0 = 32 regs (5-bit addr)
- wb_depth, 16, writeback tag space; tag width = clog2(wb_depth), minimum 1
- depth, 4, station entries; must be < wb_depth (elaboration error otherwise)
- payload_w, 32, opaque decoded-op payload width

Ports:
- clk  input  1  single clock, rising edge
- rst  input  1  reset: synchronous, active-low
- enq_valid  input  1  instruction offered
- enq_ready  output  1  station can accept
- enq_rs1_data  input  32  operand 1: data, or tag in low bits when hot
- enq_rs1_hot  input  1  operand 1 pending
- enq_rs2_data  input  32  operand 2: data, or tag when hot
- enq_rs2_hot  input  1  operand 2 pending
- enq_rd_addr  input  raddr_w  destination register
- enq_rd_tag  input  wb_tag_w  tag issued for destination
- enq_payload  input  payload_w  decoded op
- wb_addr  input  raddr_w  writeback register; nonzero = broadcast valid
- wb_tag  input  wb_tag_w  writeback tag
- wb_data  input  32  writeback result
- iss_valid  output  1  ready entry presented
- iss_ready  input  1  execute accepts
- iss_rs1  output  32  resolved operand 1
- iss_rs2  output  32  resolved operand 2
- iss_rd_addr  output  raddr_w  destination register
- iss_rd_tag  output  wb_tag_w  destination tag
- iss_payload  output  payload_w  decoded op

Behaviour:
- Reset (rst low at clk edge): all entries invalid, count=0. Outputs: enq_ready=1, iss_valid=0, all iss_* data outputs 0. Reset mid-operation discards every entry, including one being handshaken that cycle.
- Storage: collapsing queue, index 0 = oldest. Per entry: valid, two {hot, value} operand fields, rd_addr, rd_tag, payload.
- Enqueue: fires when enq_valid && enq_ready. Entry is written at index count (after collapse that cycle). enq_ready = (count < depth) and is registered-state only; there is no combinational dependence on iss_ready.
- Wakeup: broadcast is valid when wb_addr != 0. Every valid entry operand with hot=1 and value[wb_tag_w-1:0] == wb_tag captures wb_data and clears hot at that edge. Both operands of one entry may wake in the same cycle. Cold operands ignore the broadcast.
- Ready: an entry is ready when both operands are cold.
- Issue: iss_valid = any valid entry ready. iss_* come combinationally from the lowest-index ready entry; ready entries may bypass older non-ready ones. iss_* values are 0 when iss_valid=0.
- On iss_valid && iss_ready: the selected entry is removed and younger entries shift down one index in the same edge.
- Latency: an entry enqueued cold is issuable the cycle after enqueue. A hot operand woken at edge N is issuable in the cycle following edge N. There is no same-cycle wb-to-issue forwarding.
- Simultaneous enqueue + issue: both occur; count is unchanged; the new entry lands at index count-1.
- Simultaneous enqueue + matching broadcast: see Optional Feature.
- Full (count=depth): enq_ready=0 until an issue completes. The earliest re-accept is the cycle after that issue.
- Empty: iss_valid=0.
- Tag wrap: matching is pure equality. Correctness relies on depth < wb_depth and the upstream rule that a tag is not reissued while a consumer of it is resident.

Optional Feature:
- Macro: OWS_ENQ_WB_CAPTURE_EN
- Defined: an operand arriving hot whose tag equals the valid broadcast in the enqueue cycle is written cold with wb_data. enq_ready follows the normal full rule only.
- Undefined: no capture at enqueue. enq_ready is additionally deasserted in any cycle where wb_addr != 0 and a hot incoming operand's tag equals wb_tag, so that wakeup is never lost. This makes enq_ready combinational on enq_* and wb_*.

Decomposition:
- Shared package ows_pkg holds:
  - functions raddr_w(embedded) and wb_tag_w(wb_depth)
  - typedef operand_t {hot, value[31:0]}
  - typedef ows_entry_t {valid, rs1 operand_t, rs2 operand_t, rd_addr, rd_tag, payload}
- One sub-module: ows_oldest_ready_pick, a parameterised lowest-index priority picker returning a one-hot select plus an any-ready flag.

Test Plan:
- Reset → enq_ready=1, iss_valid=0. Enqueue cold rs1=0x11, rs2=0x22, rd=5, tag=3 → next cycle iss_valid=1, iss_rs1=0x11, iss_rs2=0x22, iss_rd_tag=3.
- Enqueue rs1 hot tag 7, rs2 cold 0x5. Drive wb_addr=2, wb_tag=7, wb_data=0xDEADBEEF one cycle later → iss_valid rises the next cycle with iss_rs1=0xDEADBEEF.
- Fill 4 entries with hot tag 9, iss_ready=0 → enq_ready=0. Broadcast tag 9 and pulse iss_ready for 4 cycles → issue order matches enqueue order, and enq_ready=1 the cycle after the first issue.
- Entry0 hot tag 4, entry1 cold → entry1 issues first. After wb tag 4, entry0 issues.
- Enqueue hot tag 6 in the same cycle as wb_tag=6, wb_addr=1 → with macro: issues next cycle with wb_data. Without macro: enq_ready=0 that cycle, and accepts after the broadcast drops.
- Assert rst low with 3 entries resident and iss_ready=1 → next cycle iss_valid=0, enq_ready=1, no issue completed.

Source files
------------

// File: rtl/ows_pkg.sv
`default_nettype none
// ============================================================================
// Module  : ows_pkg
// Purpose : Shared types and width helpers for the operand wakeup station.
//           Entry fields are sized to the largest supported configuration.
//           The top zero-extends into them and truncates out of them.
// Revision: 1.0 - initial release
// ============================================================================
package ows_pkg;

  localparam int RADDR_MAX_W   = 5;
  localparam int TAG_MAX_W     = 16;
  localparam int PAYLOAD_MAX_W = 128;

  // Architectural register address width: 16 regs when embedded, else 32.
  function automatic int raddr_w(input int embedded);
    return (embedded != 0) ? 4 : 5;
  endfunction

  // Writeback tag width, never narrower than one bit.
  function automatic int wb_tag_w(input int wb_depth);
    int w;
    w = $clog2(wb_depth);
    return (w < 1) ? 1 : w;
  endfunction

  // A hot operand carries its producer tag in the low bits of value.
  typedef struct packed {
    logic        hot;
    logic [31:0] value;
  } operand_t;

  typedef struct packed {
    logic                     valid;
    operand_t                 rs1;
    operand_t                 rs2;
    logic [RADDR_MAX_W-1:0]   rd_addr;
    logic [TAG_MAX_W-1:0]     rd_tag;
    logic [PAYLOAD_MAX_W-1:0] payload;
  } ows_entry_t;

endpackage
`default_nettype wire

// File: rtl/ows_oldest_ready_pick.sv
`default_nettype none
// ============================================================================
// Module  : ows_oldest_ready_pick
// Purpose : Lowest-index priority picker. Because index 0 is the oldest
//           entry, this selects the oldest requester.
// Ports   : req   - per-entry request vector
//           grant - one-hot grant, all zero when there is no request
//           any   - at least one request is present
// Revision: 1.0 - initial release
// ============================================================================
module ows_oldest_ready_pick
  import ows_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0] req,
  output logic [N-1:0] grant,
  output logic         any
);

  logic found;

  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (req[i] && !found) begin
        grant[i] = 1'b1;
        found    = 1'b1;
      end
    end
    any = |req;
  end

endmodule
`default_nettype wire

// File: rtl/operand_wakeup_station.sv
`default_nettype none
// ============================================================================
// Module  : operand_wakeup_station
// Purpose : Age-ordered collapsing reservation station. It holds decoded ops
//           whose operands may still be in flight ("hot"). It snoops the
//           writeback bus to capture their results, and issues the oldest
//           fully-ready entry.
// Ports   : clk, rst (sync, active-low)
//           enq_*  - instruction input, valid/ready handshake
//           wb_*   - writeback broadcast, valid when wb_addr != 0
//           iss_*  - issue output, valid/ready handshake (zero when idle)
// Config  : OWS_ENQ_WB_CAPTURE_EN - when defined, an incoming hot operand
//           that matches the broadcast in its enqueue cycle is written cold.
//           When undefined, such an enqueue is stalled instead (enq_ready
//           drops), so the wakeup is never lost.
// Revision: 1.0 - initial release
// ============================================================================
module operand_wakeup_station
  import ows_pkg::*;
#(
  parameter int EMBEDDED  = 1,
  parameter int WB_DEPTH  = 16,
  parameter int DEPTH     = 4,
  parameter int PAYLOAD_W = 32
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               enq_valid,
  output logic                               enq_ready,
  input  logic [31:0]                        enq_rs1_data,
  input  logic                               enq_rs1_hot,
  input  logic [31:0]                        enq_rs2_data,
  input  logic                               enq_rs2_hot,
  input  logic [ows_pkg::raddr_w(EMBEDDED)-1:0] enq_rd_addr,
  input  logic [ows_pkg::wb_tag_w(WB_DEPTH)-1:0] enq_rd_tag,
  input  logic [PAYLOAD_W-1:0]               enq_payload,
  input  logic [ows_pkg::raddr_w(EMBEDDED)-1:0] wb_addr,
  input  logic [ows_pkg::wb_tag_w(WB_DEPTH)-1:0] wb_tag,
  input  logic [31:0]                        wb_data,
  output logic                               iss_valid,
  input  logic                               iss_ready,
  output logic [31:0]                        iss_rs1,
  output logic [31:0]                        iss_rs2,
  output logic [ows_pkg::raddr_w(EMBEDDED)-1:0] iss_rd_addr,
  output logic [ows_pkg::wb_tag_w(WB_DEPTH)-1:0] iss_rd_tag,
  output logic [PAYLOAD_W-1:0]               iss_payload
);

  localparam int RADDR_W = raddr_w(EMBEDDED);
  localparam int TAG_W   = wb_tag_w(WB_DEPTH);
  localparam int CNT_W   = $clog2(DEPTH + 1);

  // Tag matching is pure equality. It is only safe if a tag cannot be
  // recycled while a consumer of it is still resident.
  if (DEPTH >= WB_DEPTH) begin : g_bad_depth
    $error("operand_wakeup_station: DEPTH must be smaller than WB_DEPTH");
  end
  if (DEPTH < 1) begin : g_bad_min_depth
    $error("operand_wakeup_station: DEPTH must be at least 1");
  end
  if (PAYLOAD_W > PAYLOAD_MAX_W || TAG_W > TAG_MAX_W) begin : g_bad_width
    $error("operand_wakeup_station: payload or tag wider than entry storage");
  end

  ows_entry_t       entries     [DEPTH];
  ows_entry_t       entries_nxt [DEPTH];
  ows_entry_t       woken       [DEPTH+1];
  ows_entry_t       new_entry;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_nxt;
  logic [CNT_W-1:0] enq_idx;
  logic [DEPTH-1:0] ready_vec;
  logic [DEPTH-1:0] sel;
  logic [DEPTH-1:0] shift;
  logic             any_ready;
  logic             wb_valid;
  logic             not_full;
  logic             rs1_hit;
  logic             rs2_hit;
  logic             fire_enq;
  logic             fire_iss;
  logic             sel_acc;

  assign wb_valid = |wb_addr;
  assign not_full = (count < CNT_W'(DEPTH));

  // Broadcast matches against operands that are still on the enqueue port.
  assign rs1_hit = wb_valid && enq_rs1_hot && (enq_rs1_data[TAG_W-1:0] == wb_tag);
  assign rs2_hit = wb_valid && enq_rs2_hot && (enq_rs2_data[TAG_W-1:0] == wb_tag);

`ifdef OWS_ENQ_WB_CAPTURE_EN
  assign enq_ready = not_full;
`else
  // Without capture-at-enqueue, a matching broadcast would be missed, so hold
  // the instruction off until the broadcast has gone.
  assign enq_ready = not_full && !(rs1_hit || rs2_hit);
`endif

  assign fire_enq = enq_valid && enq_ready;
  assign fire_iss = iss_valid && iss_ready;

  // --------------------------------------------------------------------------
  // Ready detection and oldest-ready selection
  // --------------------------------------------------------------------------
  always_comb begin
    ready_vec = '0;
    for (int i = 0; i < DEPTH; i++) begin
      ready_vec[i] = entries[i].valid && !entries[i].rs1.hot && !entries[i].rs2.hot;
    end
  end

  ows_oldest_ready_pick #(
    .N (DEPTH)
  ) u_pick (
    .req   (ready_vec),
    .grant (sel),
    .any   (any_ready)
  );

  assign iss_valid = any_ready;

  // AND-OR mux on the one-hot select. Outputs are naturally zero when idle.
  always_comb begin
    iss_rs1     = '0;
    iss_rs2     = '0;
    iss_rd_addr = '0;
    iss_rd_tag  = '0;
    iss_payload = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (sel[i]) begin
        iss_rs1     = iss_rs1     | entries[i].rs1.value;
        iss_rs2     = iss_rs2     | entries[i].rs2.value;
        iss_rd_addr = iss_rd_addr | entries[i].rd_addr[RADDR_W-1:0];
        iss_rd_tag  = iss_rd_tag  | entries[i].rd_tag[TAG_W-1:0];
        iss_payload = iss_payload | entries[i].payload[PAYLOAD_W-1:0];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Wakeup: apply the broadcast to every resident hot operand
  // --------------------------------------------------------------------------
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      woken[i] = entries[i];
      if (entries[i].valid && wb_valid) begin
        if (entries[i].rs1.hot && (entries[i].rs1.value[TAG_W-1:0] == wb_tag)) begin
          woken[i].rs1.hot   = 1'b0;
          woken[i].rs1.value = wb_data;
        end
        if (entries[i].rs2.hot && (entries[i].rs2.value[TAG_W-1:0] == wb_tag)) begin
          woken[i].rs2.hot   = 1'b0;
          woken[i].rs2.value = wb_data;
        end
      end
    end
    // Empty slot shifted into the top position when the queue collapses.
    woken[DEPTH] = '0;
  end

  // --------------------------------------------------------------------------
  // Incoming entry
  // --------------------------------------------------------------------------
  always_comb begin
    new_entry           = '0;
    new_entry.valid     = 1'b1;
    new_entry.rs1.hot   = enq_rs1_hot;
    new_entry.rs1.value = enq_rs1_data;
    new_entry.rs2.hot   = enq_rs2_hot;
    new_entry.rs2.value = enq_rs2_data;
    new_entry.rd_addr   = RADDR_MAX_W'(enq_rd_addr);
    new_entry.rd_tag    = TAG_MAX_W'(enq_rd_tag);
    new_entry.payload   = PAYLOAD_MAX_W'(enq_payload);
`ifdef OWS_ENQ_WB_CAPTURE_EN
    if (rs1_hit) begin
      new_entry.rs1.hot   = 1'b0;
      new_entry.rs1.value = wb_data;
    end
    if (rs2_hit) begin
      new_entry.rs2.hot   = 1'b0;
      new_entry.rs2.value = wb_data;
    end
`endif
  end

  // --------------------------------------------------------------------------
  // Collapse and enqueue
  // --------------------------------------------------------------------------
  // Every slot at or above the issued one takes its younger neighbour. The
  // enqueue then lands just past the last survivor.
  always_comb begin
    sel_acc = 1'b0;
    shift   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      sel_acc  = sel_acc | sel[i];
      shift[i] = fire_iss && sel_acc;
    end
  end

  assign enq_idx   = count - CNT_W'(fire_iss);
  assign count_nxt = count + CNT_W'(fire_enq) - CNT_W'(fire_iss);

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      entries_nxt[i] = shift[i] ? woken[i+1] : woken[i];
      if (fire_enq && (enq_idx == CNT_W'(i))) begin
        entries_nxt[i] = new_entry;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        entries[i] <= '0;
      end
    end else begin
      count <= count_nxt;
      for (int i = 0; i < DEPTH; i++) begin
        entries[i] <= entries_nxt[i];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_operand_wakeup_station.sv
`default_nettype none
// ============================================================================
// Module  : tb_operand_wakeup_station
// Purpose : Directed self-checking bench for operand_wakeup_station with the
//           default configuration (16 regs, 16 tags, 4 entries, 32-bit
//           payload).
// Revision: 1.0 - initial release
// ============================================================================
module tb_operand_wakeup_station;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        enq_valid = 1'b0;
  logic        enq_ready;
  logic [31:0] enq_rs1_data = '0;
  logic        enq_rs1_hot = 1'b0;
  logic [31:0] enq_rs2_data = '0;
  logic        enq_rs2_hot = 1'b0;
  logic [3:0]  enq_rd_addr = '0;
  logic [3:0]  enq_rd_tag = '0;
  logic [31:0] enq_payload = '0;
  logic [3:0]  wb_addr = '0;
  logic [3:0]  wb_tag = '0;
  logic [31:0] wb_data = '0;
  logic        iss_valid;
  logic        iss_ready = 1'b0;
  logic [31:0] iss_rs1;
  logic [31:0] iss_rs2;
  logic [3:0]  iss_rd_addr;
  logic [3:0]  iss_rd_tag;
  logic [31:0] iss_payload;

  int errors = 0;
  int checks = 0;

  operand_wakeup_station #(
    .EMBEDDED  (1),
    .WB_DEPTH  (16),
    .DEPTH     (4),
    .PAYLOAD_W (32)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .enq_valid    (enq_valid),
    .enq_ready    (enq_ready),
    .enq_rs1_data (enq_rs1_data),
    .enq_rs1_hot  (enq_rs1_hot),
    .enq_rs2_data (enq_rs2_data),
    .enq_rs2_hot  (enq_rs2_hot),
    .enq_rd_addr  (enq_rd_addr),
    .enq_rd_tag   (enq_rd_tag),
    .enq_payload  (enq_payload),
    .wb_addr      (wb_addr),
    .wb_tag       (wb_tag),
    .wb_data      (wb_data),
    .iss_valid    (iss_valid),
    .iss_ready    (iss_ready),
    .iss_rs1      (iss_rs1),
    .iss_rs2      (iss_rs2),
    .iss_rd_addr  (iss_rd_addr),
    .iss_rd_tag   (iss_rd_tag),
    .iss_payload  (iss_payload)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_enq(input logic h1, input logic [31:0] d1,
                         input logic h2, input logic [31:0] d2,
                         input logic [3:0] rd, input logic [3:0] tg,
                         input logic [31:0] pl);
    enq_rs1_hot  = h1;
    enq_rs1_data = d1;
    enq_rs2_hot  = h2;
    enq_rs2_data = d2;
    enq_rd_addr  = rd;
    enq_rd_tag   = tg;
    enq_payload  = pl;
  endtask

  task automatic enq(input logic h1, input logic [31:0] d1,
                     input logic h2, input logic [31:0] d2,
                     input logic [3:0] rd, input logic [3:0] tg,
                     input logic [31:0] pl);
    set_enq(h1, d1, h2, d2, rd, tg, pl);
    enq_valid = 1'b1;
    tick();
    enq_valid = 1'b0;
  endtask

  task automatic broadcast(input logic [3:0] a, input logic [3:0] t, input logic [31:0] d);
    wb_addr = a;
    wb_tag  = t;
    wb_data = d;
    tick();
    wb_addr = '0;
  endtask

  task automatic drain();
    iss_ready = 1'b1;
    for (int n = 0; n < 8 && iss_valid; n++) tick();
    iss_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    if (enq_ready !== 1'b1) begin errors++; $display("FAIL reset_enq_ready: got %b expected 1", enq_ready); end
    checks++;
    if (iss_valid !== 1'b0) begin errors++; $display("FAIL reset_iss_valid: got %b expected 0", iss_valid); end
    checks++;
    if (iss_rs1 !== 32'h0 || iss_payload !== 32'h0) begin
      errors++; $display("FAIL reset_iss_data: got rs1=%h payload=%h expected 0", iss_rs1, iss_payload);
    end
    checks++;
  endtask

  task automatic test_cold();
    enq(1'b0, 32'h11, 1'b0, 32'h22, 4'd5, 4'd3, 32'hA1);
    if (iss_valid !== 1'b1) begin errors++; $display("FAIL cold_iss_valid: got %b expected 1", iss_valid); end
    checks++;
    if (iss_rs1 !== 32'h11 || iss_rs2 !== 32'h22) begin
      errors++; $display("FAIL cold_operands: got %h/%h expected 11/22", iss_rs1, iss_rs2);
    end
    checks++;
    if (iss_rd_addr !== 4'd5 || iss_rd_tag !== 4'd3 || iss_payload !== 32'hA1) begin
      errors++; $display("FAIL cold_dest: got rd=%0d tag=%0d pl=%h expected 5/3/a1", iss_rd_addr, iss_rd_tag, iss_payload);
    end
    checks++;
    iss_ready = 1'b1;
    tick();
    iss_ready = 1'b0;
    if (iss_valid !== 1'b0 || iss_rs1 !== 32'h0) begin
      errors++; $display("FAIL cold_empty_after_issue: got valid=%b rs1=%h expected 0/0", iss_valid, iss_rs1);
    end
    checks++;
  endtask

  task automatic test_wakeup();
    enq(1'b1, 32'h7, 1'b0, 32'h5, 4'd1, 4'd2, 32'hB2);
    if (iss_valid !== 1'b0) begin errors++; $display("FAIL wake_hot_not_ready: got %b expected 0", iss_valid); end
    checks++;
    wb_addr = 4'd2; wb_tag = 4'd7; wb_data = 32'hDEADBEEF;
    #1;
    if (iss_valid !== 1'b0) begin errors++; $display("FAIL wake_no_forward: got %b expected 0", iss_valid); end
    checks++;
    tick();
    wb_addr = '0;
    if (iss_valid !== 1'b1 || iss_rs1 !== 32'hDEADBEEF || iss_rs2 !== 32'h5) begin
      errors++; $display("FAIL wake_issue: got valid=%b rs1=%h rs2=%h expected 1/deadbeef/5", iss_valid, iss_rs1, iss_rs2);
    end
    checks++;
    drain();
  endtask

  task automatic test_full_order();
    for (int k = 0; k < 4; k++) begin
      enq(1'b1, 32'h9, 1'b0, 32'(k), 4'(k + 1), 4'(k), 32'(k + 1));
    end
    if (enq_ready !== 1'b0) begin errors++; $display("FAIL full_enq_ready: got %b expected 0", enq_ready); end
    checks++;
    if (iss_valid !== 1'b0) begin errors++; $display("FAIL full_none_ready: got %b expected 0", iss_valid); end
    checks++;
    broadcast(4'd3, 4'd9, 32'h99);
    iss_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (iss_valid !== 1'b1 || iss_payload !== 32'(k + 1) || iss_rs1 !== 32'h99 || iss_rs2 !== 32'(k)) begin
        errors++; $display("FAIL full_order_%0d: got valid=%b pl=%h rs1=%h rs2=%h expected 1/%h/99/%h",
                           k, iss_valid, iss_payload, iss_rs1, iss_rs2, k + 1, k);
      end
      checks++;
      tick();
      if (k == 0) begin
        if (enq_ready !== 1'b1) begin errors++; $display("FAIL full_reaccept: got %b expected 1", enq_ready); end
        checks++;
      end
    end
    iss_ready = 1'b0;
    if (iss_valid !== 1'b0) begin errors++; $display("FAIL full_drained: got %b expected 0", iss_valid); end
    checks++;
  endtask

  task automatic test_bypass();
    enq(1'b1, 32'h4, 1'b0, 32'h1, 4'd2, 4'd10, 32'h10);
    enq(1'b0, 32'h4, 1'b0, 32'h2, 4'd3, 4'd11, 32'h20);
    if (iss_valid !== 1'b1 || iss_payload !== 32'h20) begin
      errors++; $display("FAIL bypass_young_first: got valid=%b pl=%h expected 1/20", iss_valid, iss_payload);
    end
    checks++;
    iss_ready = 1'b1;
    tick();
    iss_ready = 1'b0;
    broadcast(4'd0, 4'd4, 32'hBAD);
    if (iss_valid !== 1'b0) begin errors++; $display("FAIL bypass_addr0_ignored: got %b expected 0", iss_valid); end
    checks++;
    broadcast(4'd7, 4'd4, 32'h4444);
    if (iss_valid !== 1'b1 || iss_payload !== 32'h10 || iss_rs1 !== 32'h4444 || iss_rd_tag !== 4'd10) begin
      errors++; $display("FAIL bypass_old_after_wake: got valid=%b pl=%h rs1=%h tag=%0d expected 1/10/4444/10",
                         iss_valid, iss_payload, iss_rs1, iss_rd_tag);
    end
    checks++;
    drain();
  endtask

  task automatic test_dual_wake();
    enq(1'b0, 32'h5, 1'b0, 32'h1, 4'd4, 4'd12, 32'hC);
    enq(1'b1, 32'h5, 1'b1, 32'h5, 4'd5, 4'd13, 32'hD);
    broadcast(4'd1, 4'd2, 32'h22);
    iss_ready = 1'b1;
    #1;
    if (iss_payload !== 32'hC || iss_rs1 !== 32'h5) begin
      errors++; $display("FAIL dual_cold_first: got pl=%h rs1=%h expected c/5", iss_payload, iss_rs1);
    end
    checks++;
    iss_ready = 1'b0;
    broadcast(4'd1, 4'd5, 32'h55);
    if (iss_payload !== 32'hC || iss_rs1 !== 32'h5) begin
      errors++; $display("FAIL dual_cold_ignores_wb: got pl=%h rs1=%h expected c/5", iss_payload, iss_rs1);
    end
    checks++;
    iss_ready = 1'b1;
    tick();
    iss_ready = 1'b0;
    if (iss_valid !== 1'b1 || iss_payload !== 32'hD || iss_rs1 !== 32'h55 || iss_rs2 !== 32'h55) begin
      errors++; $display("FAIL dual_both_woken: got valid=%b pl=%h rs1=%h rs2=%h expected 1/d/55/55",
                         iss_valid, iss_payload, iss_rs1, iss_rs2);
    end
    checks++;
    drain();
  endtask

  task automatic test_enq_wb();
    set_enq(1'b1, 32'h6, 1'b0, 32'h3, 4'd6, 4'd14, 32'hE);
    enq_valid = 1'b1;
    wb_addr = 4'd1; wb_tag = 4'd6; wb_data = 32'h66;
    #1;
`ifdef OWS_ENQ_WB_CAPTURE_EN
    if (enq_ready !== 1'b1) begin errors++; $display("FAIL enqwb_ready: got %b expected 1", enq_ready); end
    checks++;
    tick();
    enq_valid = 1'b0;
    wb_addr = '0;
    if (iss_valid !== 1'b1 || iss_rs1 !== 32'h66) begin
      errors++; $display("FAIL enqwb_captured: got valid=%b rs1=%h expected 1/66", iss_valid, iss_rs1);
    end
    checks++;
`else
    if (enq_ready !== 1'b0) begin errors++; $display("FAIL enqwb_stall: got %b expected 0", enq_ready); end
    checks++;
    tick();
    wb_addr = '0;
    #1;
    if (enq_ready !== 1'b1) begin errors++; $display("FAIL enqwb_release: got %b expected 1", enq_ready); end
    checks++;
    tick();
    enq_valid = 1'b0;
    if (iss_valid !== 1'b0) begin errors++; $display("FAIL enqwb_still_hot: got %b expected 0", iss_valid); end
    checks++;
    broadcast(4'd1, 4'd6, 32'h66);
    if (iss_valid !== 1'b1 || iss_rs1 !== 32'h66 || iss_payload !== 32'hE) begin
      errors++; $display("FAIL enqwb_late_wake: got valid=%b rs1=%h pl=%h expected 1/66/e", iss_valid, iss_rs1, iss_payload);
    end
    checks++;
`endif
    drain();
  endtask

  task automatic test_back_to_back();
    enq(1'b0, 32'hA, 1'b0, 32'hA, 4'd1, 4'd1, 32'hAA);
    iss_ready = 1'b1;
    enq(1'b0, 32'hB, 1'b0, 32'hB, 4'd2, 4'd2, 32'hBB);
    iss_ready = 1'b0;
    if (iss_valid !== 1'b1 || iss_payload !== 32'hBB || iss_rs1 !== 32'hB) begin
      errors++; $display("FAIL b2b_new_entry: got valid=%b pl=%h rs1=%h expected 1/bb/b", iss_valid, iss_payload, iss_rs1);
    end
    checks++;
    iss_ready = 1'b1;
    tick();
    iss_ready = 1'b0;
    if (iss_valid !== 1'b0) begin errors++; $display("FAIL b2b_count_one: got %b expected 0", iss_valid); end
    checks++;
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 3; k++) begin
      enq(1'b0, 32'(k), 1'b0, 32'(k), 4'd1, 4'(k), 32'(16 + k));
    end
    iss_ready = 1'b1;
    rst = 1'b0;
    tick();
    rst = 1'b1;
    iss_ready = 1'b0;
    if (iss_valid !== 1'b0 || enq_ready !== 1'b1) begin
      errors++; $display("FAIL rstmid_state: got iss_valid=%b enq_ready=%b expected 0/1", iss_valid, enq_ready);
    end
    checks++;
    enq(1'b0, 32'h77, 1'b0, 32'h78, 4'd9, 4'd9, 32'h77);
    if (iss_valid !== 1'b1 || iss_payload !== 32'h77) begin
      errors++; $display("FAIL rstmid_fresh_head: got valid=%b pl=%h expected 1/77", iss_valid, iss_payload);
    end
    checks++;
    iss_ready = 1'b1;
    tick();
    iss_ready = 1'b0;
    if (iss_valid !== 1'b0) begin errors++; $display("FAIL rstmid_only_one: got %b expected 0", iss_valid); end
    checks++;
  endtask

  initial begin
    test_reset();
    test_cold();
    test_wakeup();
    test_full_order();
    test_bypass();
    test_dual_wake();
    test_enq_wb();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
